// File: rtl/de_morgan_sweep_checker_if.sv
// ---------------------------------------------------------------------------
// de_morgan_sweep_checker_if
// Operand/result bus between the sweep checker and a De Morgan gate under test.
//   a_out, b_out : WIDTH-bit operands driven by the checker
//   c_in         : WIDTH-bit result returned by the gate under test
// Modports:
//   master : checker side (drives a_out/b_out, reads c_in)
//   slave  : gate side    (reads a_out/b_out, drives c_in)
// ---------------------------------------------------------------------------
interface de_morgan_sweep_checker_if #(
   parameter int WIDTH = 1
) ();
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic [WIDTH-1:0] c_in;

   modport master (output a_out, output b_out, input c_in);
   modport slave  (input a_out, input b_out, output c_in);
endinterface

// File: rtl/de_morgan_sweep_checker.sv
// ---------------------------------------------------------------------------
// de_morgan_sweep_checker
// Exhaustive driver/checker for a De Morgan gate block. Every {a,b} operand
// pair is driven, held for SETTLE cycles, then the returned c is compared
// against the selected law (0: ~a & ~b, 1: ~a | ~b).
//
// Parameters: WIDTH (1..4) operand width, SETTLE (1..15) hold cycles.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   start       : one-cycle pulse, accepted only in IDLE or DONE
//   law_sel     : law choice, latched when start is accepted
//   gate        : operand/result bus (master modport)
//   busy        : sweep in progress
//   done        : sweep finished (until next accepted start)
//   pass        : done with zero mismatches
//   err_count   : mismatching vectors in the last sweep
//   fail_valid  : fail_vec holds a captured mismatch
//   fail_vec    : first failing vector {a,b}
// Optional build macro: DE_MORGAN_STOP_ON_FAIL_EN -- when defined the sweep
// ends at the first mismatch and the operands stay on the failing vector.
// ---------------------------------------------------------------------------
module de_morgan_sweep_checker #(
   parameter int WIDTH  = 1,
   parameter int SETTLE = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      law_sel,
   de_morgan_sweep_checker_if.master gate,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [2*WIDTH:0]          err_count,
   output logic                      fail_valid,
   output logic [2*WIDTH-1:0]        fail_vec
);
   localparam int VW = 2 * WIDTH;
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [VW-1:0]    vec_reg;
   logic [3:0]       wait_reg;
   logic             law_reg;
   logic [VW:0]      err_reg;
   logic             fail_valid_reg;
   logic [VW-1:0]    fail_vec_reg;
   logic [WIDTH-1:0] exp_c;
   logic             accept;
   logic             mismatch;
   logic             last_vec;

   // Operands come straight from the vector register, so they only move
   // when the vector advances.
   assign gate.a_out = vec_reg[VW-1:WIDTH];
   assign gate.b_out = vec_reg[WIDTH-1:0];

   // Per-bit expected result for the latched law.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exp
      assign exp_c[gi] = law_reg ? (~vec_reg[WIDTH+gi] | ~vec_reg[gi])
                                 : (~vec_reg[WIDTH+gi] & ~vec_reg[gi]);
   end

   assign accept   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
   assign mismatch = (gate.c_in != exp_c);
   assign last_vec = &vec_reg;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) state_next = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (wait_reg == SETTLE_LAST) state_next = ST_CHECK;
         end
         ST_CHECK: begin
`ifdef DE_MORGAN_STOP_ON_FAIL_EN
            if (mismatch || last_vec) state_next = ST_DONE;
            else                      state_next = ST_SETTLE;
`else
            if (last_vec) state_next = ST_DONE;
            else          state_next = ST_SETTLE;
`endif
         end
         ST_DONE: begin
            if (start) state_next = ST_SETTLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_reg == ST_SETTLE) || (state_reg == ST_CHECK);
      done = (state_reg == ST_DONE);
      pass = (state_reg == ST_DONE) && (err_reg == '0);
   end

   // Sweep datapath: vector, settle counter, law latch and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_reg        <= '0;
         wait_reg       <= '0;
         law_reg        <= 1'b0;
         err_reg        <= '0;
         fail_valid_reg <= 1'b0;
         fail_vec_reg   <= '0;
      end else if (accept) begin
         vec_reg        <= '0;
         wait_reg       <= 4'd1;
         law_reg        <= law_sel;
         err_reg        <= '0;
         fail_valid_reg <= 1'b0;
         fail_vec_reg   <= '0;
      end else begin
         if (state_reg == ST_SETTLE) begin
            wait_reg <= wait_reg + 4'd1;
         end
         if (state_reg == ST_CHECK) begin
            if (mismatch) begin
               // Width VW+1 holds 2^VW, so the count can never wrap.
               err_reg <= err_reg + (VW+1)'(1);
               if (!fail_valid_reg) begin
                  fail_valid_reg <= 1'b1;
                  fail_vec_reg   <= vec_reg;
               end
            end
            if (state_next == ST_SETTLE) begin
               vec_reg  <= vec_reg + VW'(1);
               wait_reg <= 4'd1;
            end
         end
      end
   end

   assign err_count  = err_reg;
   assign fail_valid = fail_valid_reg;
   assign fail_vec   = fail_vec_reg;
endmodule

// File: tb/tb_de_morgan_sweep_checker.sv
module tb_de_morgan_sweep_checker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Gate models: 0 = NOR (~a&~b), 1 = NAND (~a|~b), 2 = stuck-at-0
   int mode1 = 0;
   int mode2 = 0;

   de_morgan_sweep_checker_if #(.WIDTH(1)) g1 ();
   de_morgan_sweep_checker_if #(.WIDTH(2)) g2 ();

   logic       start1 = 1'b0, law1 = 1'b0, start2 = 1'b0, law2 = 1'b0;
   logic       busy1, done1, pass1, fv1;
   logic [2:0] err1;
   logic [1:0] fvec1;
   logic       busy2, done2, pass2, fv2;
   logic [4:0] err2;
   logic [3:0] fvec2;

   de_morgan_sweep_checker #(.WIDTH(1), .SETTLE(2)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .law_sel(law1), .gate(g1.master),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_valid(fv1), .fail_vec(fvec1));

   de_morgan_sweep_checker #(.WIDTH(2), .SETTLE(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .law_sel(law2), .gate(g2.master),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .fail_valid(fv2), .fail_vec(fvec2));

   function automatic logic [3:0] gate_f(input int mode, input logic [3:0] a, input logic [3:0] b);
      case (mode)
         0:       return ~a & ~b;
         1:       return ~a | ~b;
         default: return 4'b0000;
      endcase
   endfunction

   logic [3:0] t1, t2;
   always_comb begin
      t1 = gate_f(mode1, {3'b000, g1.a_out}, {3'b000, g1.b_out});
      t2 = gate_f(mode2, {2'b00, g2.a_out}, {2'b00, g2.b_out});
   end
   assign g1.c_in = t1[0:0];
   assign g2.c_in = t2[1:0];

   typedef struct {
      int dut;
      int mode;
      bit law;
      int err;
      bit fv;
      int fvec;
      bit pass;
      int cycles;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   exp_t tbl[9];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // With stop-on-fail the sweep ends on the first failing vector.
   function automatic exp_t fix(input exp_t e);
      exp_t r = e;
`ifdef DE_MORGAN_STOP_ON_FAIL_EN
      if (r.err > 0) begin
         r.err    = 1;
         r.cycles = (r.fvec + 1) * 3;
      end
`endif
      return r;
   endfunction

   task automatic drive_start(input int dut, input logic s, input logic l);
      if (dut == 1) begin start1 = s; law1 = l; end
      else          begin start2 = s; law2 = l; end
   endtask

   task automatic sample(input int dut, output int b, output int d, output int v);
      if (dut == 1) begin b = int'(busy1); d = int'(done1); v = int'({g1.a_out, g1.b_out}); end
      else          begin b = int'(busy2); d = int'(done2); v = int'({g2.a_out, g2.b_out}); end
   endtask

   task automatic results(input int dut, output int err, output int fv, output int fvec, output int ps);
      if (dut == 1) begin err = int'(err1); fv = int'(fv1); fvec = int'(fvec1); ps = int'(pass1); end
      else          begin err = int'(err2); fv = int'(fv2); fvec = int'(fvec2); ps = int'(pass2); end
   endtask

   // Push the expectation, then pulse start for one cycle.
   task automatic launch(input exp_t e);
      if (e.dut == 1) begin mode1 = e.mode; q1.push_back(fix(e)); end
      else            begin mode2 = e.mode; q2.push_back(fix(e)); end
      @(negedge clk);
      drive_start(e.dut, 1'b1, e.law);
      @(negedge clk);
      drive_start(e.dut, 1'b0, e.law);
   endtask

   // Follow the sweep: check vector order, count busy cycles, optionally
   // inject a start pulse mid-sweep, then pop and compare at done.
   task automatic wait_done(input int dut, input int inject_at);
      exp_t e;
      int cyc = 0, last = -1, b, d, v, err, fv, fvec, ps;
      bit seen = 0, inj = 0, inj_law = 0;
      for (int i = 0; i < 400; i++) begin
         sample(dut, b, d, v);
         if (inj) begin drive_start(dut, 1'b0, inj_law); inj = 0; end
         if (d != 0) begin seen = 1; break; end
         if (b != 0) begin
            cyc++;
            if (v != last) begin
               if (last < 0) chk("first_vec", v, 0);
               else          chk("vec_step", v, last + 1);
               last = v;
            end
            if (cyc == inject_at) begin
               inj_law = (dut == 1) ? ~q1[0].law : ~q2[0].law;
               drive_start(dut, 1'b1, inj_law);
               inj = 1;
            end
         end
         @(negedge clk);
      end
      if ((dut == 1 && q1.size() == 0) || (dut == 2 && q2.size() == 0)) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = (dut == 1) ? q1.pop_front() : q2.pop_front();
         if (!seen) begin
            chk("done_timeout", 0, 1);
         end else begin
            results(dut, err, fv, fvec, ps);
            chk("err_count", err, e.err);
            chk("fail_valid", fv, int'(e.fv));
            chk("fail_vec", fvec, e.fvec);
            chk("pass", ps, int'(e.pass));
            chk("busy_cycles", cyc, e.cycles);
            chk("busy_at_done", b, 0);
            $display("sweep dut%0d mode=%0d law=%0d err=%0d fv=%0d fvec=%0d pass=%0d cycles=%0d",
                     dut, e.mode, e.law, err, fv, fvec, ps, cyc);
         end
      end
   endtask

   task automatic chk_idle1(input string tag);
      chk({tag, "_busy"}, int'(busy1), 0);
      chk({tag, "_done"}, int'(done1), 0);
      chk({tag, "_pass"}, int'(pass1), 0);
      chk({tag, "_err"}, int'(err1), 0);
      chk({tag, "_fail_valid"}, int'(fv1), 0);
      chk({tag, "_fail_vec"}, int'(fvec1), 0);
      chk({tag, "_a"}, int'(g1.a_out), 0);
      chk({tag, "_b"}, int'(g1.b_out), 0);
   endtask

   initial begin
      int b, d, v;
      bit found;
      //           dut mode law err fv fvec pass cycles
      tbl[0] = '{1, 0, 1'b0, 0,  1'b0, 0, 1'b1, 12};  // correct NOR
      tbl[1] = '{1, 1, 1'b0, 2,  1'b1, 1, 1'b0, 12};  // NAND vs law 0
      tbl[2] = '{1, 2, 1'b0, 1,  1'b1, 0, 1'b0, 12};  // stuck-at-0 vs law 0
      tbl[3] = '{1, 1, 1'b1, 0,  1'b0, 0, 1'b1, 12};  // correct NAND
      tbl[4] = '{1, 0, 1'b1, 2,  1'b1, 1, 1'b0, 12};  // NOR vs law 1
      tbl[5] = '{1, 2, 1'b1, 3,  1'b1, 0, 1'b0, 12};  // stuck-at-0 vs law 1
      tbl[6] = '{2, 1, 1'b1, 0,  1'b0, 0, 1'b1, 48};  // WIDTH=2 correct NAND
      tbl[7] = '{2, 2, 1'b0, 7,  1'b1, 0, 1'b0, 48};  // WIDTH=2 stuck-at-0
      tbl[8] = '{2, 1, 1'b0, 12, 1'b1, 1, 1'b0, 48};  // WIDTH=2 NAND vs law 0

      repeat (3) @(negedge clk);
      chk_idle1("reset");
      chk("reset_busy2", int'(busy2), 0);
      chk("reset_done2", int'(done2), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         launch(tbl[i]);
         wait_done(tbl[i].dut, 0);
      end

      // Reset in the middle of a failing sweep.
      launch(tbl[1]);
      found = 0;
      for (int i = 0; i < 100; i++) begin
         sample(1, b, d, v);
         if (v == 2 || d != 0) begin found = 1; break; end
         @(negedge clk);
      end
      chk("abort_reached", int'(found), 1);
      #2 rst = 1'b1;
      #1 chk_idle1("abort");
      @(negedge clk);
      rst = 1'b0;
      q1.delete();
      launch(tbl[0]);
      wait_done(1, 0);

      // Start pulse with the opposite law mid-sweep must be ignored.
      launch(tbl[0]);
      wait_done(1, 5);

      // Start from DONE: done drops next cycle, new law is latched.
      launch(tbl[4]);
      chk("restart_done_low", int'(done1), 0);
      chk("restart_busy", int'(busy1), 1);
      wait_done(1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/de_morgan_sweep_checker.md
Name: de_morgan_sweep_checker

Overview:
- Exhaustive stimulus driver and response checker for De Morgan gate blocks.
- Drives every combination of a/b operand vectors into a gate under test, waits a settle window, samples the gate output and compares it against the expected law.
- Sits at the board/bench boundary: the driver/checker end of the a/b→c gate interface. Reports pass/fail, error count and the first failing vector.

Parameters:
- WIDTH, 1, bit width of each operand a/b and of the result c. Legal range 1..4.
- SETTLE, 2, cycles vector is held before sampling c_in. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a sweep.
- law_sel  input  1  0: expect c = ~a & ~b; 1: expect c = ~a | ~b. Sampled on accepted start.
- a_out  output  WIDTH  operand a to the gate under test.
- b_out  output  WIDTH  operand b to the gate under test.
- c_in  input  WIDTH  result returned from the gate under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- pass  output  1  done && err_count == 0.
- err_count  output  2*WIDTH+1  number of mismatching vectors in the last sweep.
- fail_valid  output  1  a mismatch has been recorded this sweep.
- fail_vec  output  2*WIDTH  first failing vector {a_out,b_out}.

Behaviour:
Reset:
- State IDLE; vector counter 0; a_out/b_out 0.
- busy, done, pass, fail_valid all 0; err_count 0; fail_vec 0.
- Reset asserted mid-sweep aborts immediately to these values. No partial results are kept.

Vector counter and drive:
- vec is 2*WIDTH bits, with a_out = vec[2W-1:W] and b_out = vec[W-1:0].
- Sweep order is 0 up to 2^(2W)-1, with no wrap.
- a_out/b_out are registered and change only on a vector transition.

Expected value:
- Registered law bit; law 0 gives exp = ~a_out & ~b_out, law 1 gives exp = ~a_out | ~b_out.
- Comparison is a full WIDTH-bit equality. Any differing bit counts as one mismatch for that vector.

FSM:
- IDLE: start → SETTLE, with vec=0, clears err_count/fail_valid/fail_vec, latches law_sel, busy=1.
- SETTLE: wait counter runs 1..SETTLE; after SETTLE cycles → CHECK.
- CHECK (one cycle): sample c_in and compare.
  - On mismatch, err_count += 1. If fail_valid is 0, capture fail_vec = vec and set fail_valid.
  - If vec is all-ones → DONE. Otherwise vec += 1 → SETTLE.
- DONE: busy=0, done=1, pass valid. start → same action as from IDLE (done drops the next cycle).

Timing:
- Each vector occupies SETTLE+1 cycles. busy rises the cycle after start.
- done rises 2^(2W)*(SETTLE+1) cycles after busy rises.

Boundary conditions:
- start while busy: ignored, with no restart and no effect on law.
- err_count saturation: cannot overflow, since its width holds 2^(2W).
- c_in is treated as synchronous; the bench/DUT path must settle within SETTLE cycles.
- start and the final CHECK in the same cycle: start is ignored (still busy).

Optional Feature:
- Macro: DE_MORGAN_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK moves directly to DONE. err_count = 1, fail_vec holds the offending vector, and a_out/b_out stay held at that vector for scope inspection.
- Undefined: the sweep always runs all 2^(2W) vectors, as above.

Test Plan:
- Correct NOR DUT, WIDTH=1, SETTLE=2, law 0, start: a/b sweep 00,01,10,11; done after 12 cycles of busy; err_count=0, pass=1, fail_valid=0.
- Wrong DUT (c = ~a|~b) against law 0, WIDTH=1: mismatches at vec 01 and 10; err_count=2, fail_vec=2'b01, fail_valid=1, pass=0.
- Correct NAND DUT, WIDTH=2, law 1: 16 vectors, done after 48 busy cycles; err_count=0, pass=1.
- Stuck-at-0 c_in, WIDTH=1, law 0: only vec 00 fails; err_count=1, fail_vec=2'b00. With DE_MORGAN_STOP_ON_FAIL_EN defined: DONE 3 cycles after busy, a_out=b_out=0 held.
- Reset mid-sweep (assert at vec 2): outputs are immediately all 0 and IDLE. A new start runs a clean sweep with err_count starting at 0.
- Start pulse while busy, plus start in DONE: the mid-sweep pulse is ignored and the total cycle count is unchanged. A start in DONE clears done the next cycle and restarts at vec 0 with the newly latched law_sel.
